// File: rtl/gpr_inflight_tracker.sv
// gpr_inflight_tracker: per-wavefront table of in-flight GPR destinations.
// Define GPR_TRACKER_RANGE_CHECK_EN for [addr, addr+size) overlap compare.
module gpr_inflight_tracker #(
  parameter int WF_PER_CU = 40,
  parameter int WFID_W    = 6,
  parameter int OPERANDS  = 4,
  parameter int ENTRIES   = 4,
  parameter int ADDR_W    = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dec_valid,
  input  logic [WFID_W-1:0]        dec_wfid,
  input  logic [OPERANDS-1:0]      dec_op_valid,
  input  logic [OPERANDS*ADDR_W-1:0] dec_op_addr,
  input  logic [OPERANDS*2-1:0]    dec_op_size,
  input  logic                     alu_done,
  input  logic [WFID_W-1:0]        alu_done_wfid,
  input  logic [ADDR_W-1:0]        alu_done_addr,
  input  logic                     lsu_done,
  input  logic [WFID_W-1:0]        lsu_done_wfid,
  input  logic [ADDR_W-1:0]        lsu_done_addr,
  output logic [OPERANDS-1:0]      decode_instr_data,
  output logic [WFID_W-1:0]        decode_wfid,
  output logic                     decode_valid,
  output logic [OPERANDS-1:0]      alu_set_data,
  output logic [WFID_W-1:0]        alu_set_wfid,
  output logic [OPERANDS-1:0]      lsu_set_data,
  output logic [WFID_W-1:0]        lsu_set_wfid,
  output logic [WF_PER_CU-1:0]     wf_full,
  output logic                     overflow_err
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int DST   = OPERANDS - 1;

  logic [ENTRIES-1:0]  r_valid    [WF_PER_CU];
  logic [ADDR_W-1:0]   r_addr     [WF_PER_CU][ENTRIES];
  logic [OPERANDS-1:0] r_wait_v   [WF_PER_CU];
  logic [IDX_W-1:0]    r_wait_idx [WF_PER_CU][OPERANDS];
`ifdef GPR_TRACKER_RANGE_CHECK_EN
  logic [1:0]          r_size     [WF_PER_CU][ENTRIES];
`endif

  logic [OPERANDS-1:0] r_dec_data;
  logic [WFID_W-1:0]   r_dec_wfid;
  logic                r_dec_valid;
  logic [OPERANDS-1:0] r_alu_set;
  logic [WFID_W-1:0]   r_alu_wfid;
  logic [OPERANDS-1:0] r_lsu_set;
  logic [WFID_W-1:0]   r_lsu_wfid;
  logic                r_ovf;

`ifdef GPR_TRACKER_RANGE_CHECK_EN
  function automatic logic [ADDR_W-1:0] f_cnt(
    input logic [1:0] s
  );
    case (s)
      2'd0:    return ADDR_W'(1);
      2'd1:    return ADDR_W'(2);
      default: return ADDR_W'(4);
    endcase
  endfunction

  // Type bit must agree; ranges compare on the low bits only.
  function automatic logic f_hit(
    input logic [ADDR_W-1:0] a,
    input logic [1:0]        as,
    input logic [ADDR_W-1:0] b,
    input logic [1:0]        bs
  );
    logic [ADDR_W-1:0] la;
    logic [ADDR_W-1:0] lb;
    la = {1'b0, a[ADDR_W-2:0]};
    lb = {1'b0, b[ADDR_W-2:0]};
    return (a[ADDR_W-1] == b[ADDR_W-1]) &&
           (la < lb + f_cnt(bs)) &&
           (lb < la + f_cnt(as));
  endfunction
`else
  function automatic logic f_hit(
    input logic [ADDR_W-1:0] a,
    input logic [ADDR_W-1:0] b
  );
    return a == b;
  endfunction

  logic w_unused_size;
  assign w_unused_size = ^dec_op_size;
`endif

  logic [1:0]          w_rt_done;
  logic [WFID_W-1:0]   w_rt_wfid [2];
  logic [ADDR_W-1:0]   w_rt_addr [2];
  logic [1:0]          w_rt_hit;
  logic [IDX_W-1:0]    w_rt_idx  [2];
  logic [OPERANDS-1:0] w_rt_set  [2];

  assign w_rt_done    = {lsu_done, alu_done};
  assign w_rt_wfid[0] = alu_done_wfid;
  assign w_rt_wfid[1] = lsu_done_wfid;
  assign w_rt_addr[0] = alu_done_addr;
  assign w_rt_addr[1] = lsu_done_addr;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rt_hit[p] = 1'b0;
      w_rt_idx[p] = '0;
      w_rt_set[p] = '0;
      for (int w = 0; w < WF_PER_CU; w++) begin
        if (w_rt_done[p] && w_rt_wfid[p] == WFID_W'(w)) begin
          for (int e = ENTRIES - 1; e >= 0; e--) begin
            if (r_valid[w][e] &&
                r_addr[w][e] == w_rt_addr[p]) begin
              w_rt_hit[p] = 1'b1;
              w_rt_idx[p] = IDX_W'(e);
            end
          end
        end
      end
      for (int w = 0; w < WF_PER_CU; w++) begin
        if (w_rt_hit[p] && w_rt_wfid[p] == WFID_W'(w)) begin
          for (int i = 0; i < OPERANDS; i++) begin
            w_rt_set[p][i] = r_wait_v[w][i] &&
                             r_wait_idx[w][i] == w_rt_idx[p];
          end
        end
      end
    end
  end

  // Entry view of the decoding wavefront after this cycle's retires.
  logic [ENTRIES-1:0] w_dvalid;
  logic [ADDR_W-1:0]  w_daddr [ENTRIES];
`ifdef GPR_TRACKER_RANGE_CHECK_EN
  logic [1:0]         w_dsize [ENTRIES];
`endif

  always_comb begin
    w_dvalid = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      w_daddr[e] = '0;
`ifdef GPR_TRACKER_RANGE_CHECK_EN
      w_dsize[e] = '0;
`endif
    end
    for (int w = 0; w < WF_PER_CU; w++) begin
      if (dec_wfid == WFID_W'(w)) begin
        w_dvalid = r_valid[w];
        for (int e = 0; e < ENTRIES; e++) begin
          w_daddr[e] = r_addr[w][e];
`ifdef GPR_TRACKER_RANGE_CHECK_EN
          w_dsize[e] = r_size[w][e];
`endif
        end
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (w_rt_hit[p] && w_rt_wfid[p] == dec_wfid) begin
        w_dvalid[w_rt_idx[p]] = 1'b0;
      end
    end
  end

  logic [OPERANDS-1:0] w_dep;
  logic [IDX_W-1:0]    w_dep_idx [OPERANDS];

  always_comb begin
    w_dep = '0;
    for (int i = 0; i < OPERANDS; i++) begin
      w_dep_idx[i] = '0;
      for (int e = 0; e < ENTRIES; e++) begin
        if (dec_valid && dec_op_valid[i] && w_dvalid[e] &&
`ifdef GPR_TRACKER_RANGE_CHECK_EN
            f_hit(dec_op_addr[ADDR_W*i +: ADDR_W],
                  dec_op_size[2*i +: 2],
                  w_daddr[e], w_dsize[e])) begin
`else
            f_hit(dec_op_addr[ADDR_W*i +: ADDR_W],
                  w_daddr[e])) begin
`endif
          w_dep[i]     = 1'b1;
          w_dep_idx[i] = IDX_W'(e);
        end
      end
    end
  end

  logic               w_alloc_req;
  logic               w_alloc;
  logic               w_ovf;
  logic [IDX_W-1:0]   w_alloc_idx;

  always_comb begin
    w_alloc_idx = '0;
    for (int e = ENTRIES - 1; e >= 0; e--) begin
      if (!w_dvalid[e]) w_alloc_idx = IDX_W'(e);
    end
    w_alloc_req = dec_valid && dec_op_valid[DST];
    w_alloc     = w_alloc_req && !(&w_dvalid);
    w_ovf       = w_alloc_req && (&w_dvalid);
  end

  logic [ENTRIES-1:0]  w_vclr [WF_PER_CU];
  logic [ENTRIES-1:0]  w_vset [WF_PER_CU];
  logic [OPERANDS-1:0] w_wclr [WF_PER_CU];

  always_comb begin
    for (int w = 0; w < WF_PER_CU; w++) begin
      w_vclr[w] = '0;
      w_vset[w] = '0;
      w_wclr[w] = '0;
      for (int p = 0; p < 2; p++) begin
        if (w_rt_hit[p] && w_rt_wfid[p] == WFID_W'(w)) begin
          w_vclr[w][w_rt_idx[p]] = 1'b1;
          w_wclr[w] = w_wclr[w] | w_rt_set[p];
        end
      end
      if (w_alloc && dec_wfid == WFID_W'(w)) begin
        w_vset[w][w_alloc_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < WF_PER_CU; w++) begin
        r_valid[w]  <= '0;
        r_wait_v[w] <= '0;
        for (int e = 0; e < ENTRIES; e++) begin
          r_addr[w][e] <= '0;
`ifdef GPR_TRACKER_RANGE_CHECK_EN
          r_size[w][e] <= '0;
`endif
        end
        for (int i = 0; i < OPERANDS; i++) begin
          r_wait_idx[w][i] <= '0;
        end
      end
    end else begin
      for (int w = 0; w < WF_PER_CU; w++) begin
        r_valid[w] <= (r_valid[w] & ~w_vclr[w]) | w_vset[w];
        for (int e = 0; e < ENTRIES; e++) begin
          if (w_vset[w][e]) begin
            r_addr[w][e] <= dec_op_addr[ADDR_W*DST +: ADDR_W];
`ifdef GPR_TRACKER_RANGE_CHECK_EN
            r_size[w][e] <= dec_op_size[2*DST +: 2];
`endif
          end
        end
        if (dec_valid && dec_wfid == WFID_W'(w)) begin
          r_wait_v[w] <= w_dep;
          for (int i = 0; i < OPERANDS; i++) begin
            r_wait_idx[w][i] <= w_dep_idx[i];
          end
        end else begin
          r_wait_v[w] <= r_wait_v[w] & ~w_wclr[w];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dec_data  <= '0;
      r_dec_wfid  <= '0;
      r_dec_valid <= 1'b0;
      r_alu_set   <= '0;
      r_alu_wfid  <= '0;
      r_lsu_set   <= '0;
      r_lsu_wfid  <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_dec_valid <= dec_valid;
      r_dec_data  <= w_dep;
      r_dec_wfid  <= dec_valid ? dec_wfid : '0;
      r_alu_set   <= w_rt_set[0];
      r_alu_wfid  <= alu_done ? alu_done_wfid : '0;
      r_lsu_set   <= w_rt_set[1];
      r_lsu_wfid  <= lsu_done ? lsu_done_wfid : '0;
      r_ovf       <= r_ovf | w_ovf;
    end
  end

  always_comb begin
    wf_full = '0;
    for (int w = 0; w < WF_PER_CU; w++) begin
      wf_full[w] = &r_valid[w];
    end
  end

  assign decode_instr_data = r_dec_data;
  assign decode_wfid       = r_dec_wfid;
  assign decode_valid      = r_dec_valid;
  assign alu_set_data      = r_alu_set;
  assign alu_set_wfid      = r_alu_wfid;
  assign lsu_set_data      = r_lsu_set;
  assign lsu_set_wfid      = r_lsu_wfid;
  assign overflow_err      = r_ovf;

endmodule

// File: tb/tb_gpr_inflight_tracker.sv
// Scoreboard bench for gpr_inflight_tracker: directed decode/retire vectors.
// Range-dependent expectations follow GPR_TRACKER_RANGE_CHECK_EN.
module tb_gpr_inflight_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid;
  logic [5:0]  dec_wfid;
  logic [3:0]  dec_op_valid;
  logic [39:0] dec_op_addr;
  logic [7:0]  dec_op_size;
  logic        alu_done;
  logic [5:0]  alu_done_wfid;
  logic [9:0]  alu_done_addr;
  logic        lsu_done;
  logic [5:0]  lsu_done_wfid;
  logic [9:0]  lsu_done_addr;
  logic [3:0]  decode_instr_data;
  logic [5:0]  decode_wfid;
  logic        decode_valid;
  logic [3:0]  alu_set_data;
  logic [5:0]  alu_set_wfid;
  logic [3:0]  lsu_set_data;
  logic [5:0]  lsu_set_wfid;
  logic [39:0] wf_full;
  logic        overflow_err;

  gpr_inflight_tracker dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_wfid(dec_wfid),
    .dec_op_valid(dec_op_valid), .dec_op_addr(dec_op_addr),
    .dec_op_size(dec_op_size),
    .alu_done(alu_done), .alu_done_wfid(alu_done_wfid),
    .alu_done_addr(alu_done_addr),
    .lsu_done(lsu_done), .lsu_done_wfid(lsu_done_wfid),
    .lsu_done_addr(lsu_done_addr),
    .decode_instr_data(decode_instr_data),
    .decode_wfid(decode_wfid), .decode_valid(decode_valid),
    .alu_set_data(alu_set_data), .alu_set_wfid(alu_set_wfid),
    .lsu_set_data(lsu_set_data), .lsu_set_wfid(lsu_set_wfid),
    .wf_full(wf_full), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

`ifdef GPR_TRACKER_RANGE_CHECK_EN
  localparam logic [3:0] EXP_RANGE = 4'b0110;
`else
  localparam logic [3:0] EXP_RANGE = 4'b0100;
`endif

  int checks = 0;
  int errors = 0;
  logic [9:0] q_dec[$];
  logic [9:0] q_alu[$];
  logic [9:0] q_lsu[$];
  logic tb_dec_q, tb_alu_q, tb_lsu_q;
  logic [9:0] m_dec, m_alu, m_lsu;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      tb_dec_q <= 1'b0;
      tb_alu_q <= 1'b0;
      tb_lsu_q <= 1'b0;
    end else begin
      tb_dec_q <= dec_valid;
      tb_alu_q <= alu_done;
      tb_lsu_q <= lsu_done;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("decode_valid", 64'(decode_valid), 64'(tb_dec_q));
      if (tb_dec_q) begin
        if (q_dec.size() == 0) begin
          checks++; errors++;
          $display("FAIL dec_queue: got output expected none queued");
        end else begin
          m_dec = q_dec.pop_front();
          chk("decode_data", 64'(decode_instr_data), 64'(m_dec[9:6]));
          chk("decode_wfid", 64'(decode_wfid), 64'(m_dec[5:0]));
        end
      end else begin
        chk("decode_idle", 64'(decode_instr_data), 0);
      end
      if (tb_alu_q) begin
        if (q_alu.size() == 0) begin
          checks++; errors++;
          $display("FAIL alu_queue: got output expected none queued");
        end else begin
          m_alu = q_alu.pop_front();
          chk("alu_set", 64'(alu_set_data), 64'(m_alu[9:6]));
          if (m_alu[9:6] != 4'b0)
            chk("alu_wfid", 64'(alu_set_wfid), 64'(m_alu[5:0]));
        end
      end else begin
        chk("alu_idle", 64'(alu_set_data), 0);
      end
      if (tb_lsu_q) begin
        if (q_lsu.size() == 0) begin
          checks++; errors++;
          $display("FAIL lsu_queue: got output expected none queued");
        end else begin
          m_lsu = q_lsu.pop_front();
          chk("lsu_set", 64'(lsu_set_data), 64'(m_lsu[9:6]));
          if (m_lsu[9:6] != 4'b0)
            chk("lsu_wfid", 64'(lsu_set_wfid), 64'(m_lsu[5:0]));
        end
      end else begin
        chk("lsu_idle", 64'(lsu_set_data), 0);
      end
    end
  end

  task automatic idle_inputs();
    dec_valid = 0; dec_wfid = 0; dec_op_valid = 0;
    dec_op_addr = 0; dec_op_size = 0;
    alu_done = 0; alu_done_wfid = 0; alu_done_addr = 0;
    lsu_done = 0; lsu_done_wfid = 0; lsu_done_addr = 0;
  endtask

  task automatic dec(input logic [5:0] wf, input logic [3:0] opv,
                     input logic [9:0] a0, input logic [9:0] a1,
                     input logic [9:0] a2, input logic [9:0] a3,
                     input logic [7:0] sz, input logic [3:0] exp);
    dec_valid = 1; dec_wfid = wf; dec_op_valid = opv;
    dec_op_addr = {a3, a2, a1, a0}; dec_op_size = sz;
    q_dec.push_back({exp, wf});
  endtask

  task automatic alu(input logic [5:0] wf, input logic [9:0] a,
                     input logic [3:0] exp);
    alu_done = 1; alu_done_wfid = wf; alu_done_addr = a;
    q_alu.push_back({exp, wf});
  endtask

  task automatic lsu(input logic [5:0] wf, input logic [9:0] a,
                     input logic [3:0] exp);
    lsu_done = 1; lsu_done_wfid = wf; lsu_done_addr = a;
    q_lsu.push_back({exp, wf});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dvalid"}, 64'(decode_valid), 0);
    chk({tag, "_ddata"}, 64'(decode_instr_data), 0);
    chk({tag, "_dwfid"}, 64'(decode_wfid), 0);
    chk({tag, "_alu"}, 64'({alu_set_data, alu_set_wfid}), 0);
    chk({tag, "_lsu"}, 64'({lsu_set_data, lsu_set_wfid}), 0);
    chk({tag, "_full"}, 64'(wf_full), 0);
    chk({tag, "_ovf"}, 64'(overflow_err), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    idle_inputs();
    #3;
    chk_all_zero("reset");
    #9;
    rst = 1'b1;
    @(posedge clk);
    #1;

    dec(3, 4'b1000, 0, 0, 0, 10'h205, 0, 4'b0000); tick();
    dec(3, 4'b0001, 10'h205, 0, 0, 0, 0, 4'b0001); tick();
    alu(3, 10'h205, 4'b0001); tick();
    dec(3, 4'b0001, 10'h205, 0, 0, 0, 0, 4'b0000); tick();
    dec(3, 4'b1000, 0, 0, 0, 10'h205, 0, 4'b0000); tick();
    dec(3, 4'b0011, 10'h005, 10'h205, 0, 0, 0, 4'b0010); tick();
    dec(3, 4'b1000, 0, 0, 0, 10'h206, 0, 4'b0000); tick();
    dec(3, 4'b0011, 10'h206, 10'h205, 0, 0, 0, 4'b0011); tick();
    alu(3, 10'h205, 4'b0010);
    lsu(3, 10'h206, 4'b0001); tick();
    dec(3, 4'b1000, 0, 0, 0, 10'h207, 0, 4'b0000); tick();
    dec(3, 4'b0100, 0, 0, 10'h207, 0, 0, 4'b0100); tick();
    alu(3, 10'h207, 4'b0100);
    lsu(3, 10'h207, 4'b0100); tick();
    dec(3, 4'b0100, 0, 0, 10'h207, 0, 0, 4'b0000); tick();

    dec(5, 4'b1000, 0, 0, 0, 10'h004, 8'b01_00_00_00, 4'b0000); tick();
    dec(5, 4'b0111, 10'h006, 10'h005, 10'h004, 0, 0, EXP_RANGE); tick();

    for (int k = 0; k < 4; k++) begin
      dec(7, 4'b1000, 0, 0, 0, 10'h210 + 10'(k), 0, 4'b0000);
      tick();
    end
    chk("full_after_fill", 64'(wf_full), 64'h80);
    chk("ovf_before", 64'(overflow_err), 0);
    dec(7, 4'b1001, 10'h212, 0, 0, 10'h214, 0, 4'b0001); tick();
    chk("ovf_set", 64'(overflow_err), 1);
    chk("full_on_ovf", 64'(wf_full), 64'h80);
    lsu(7, 10'h212, 4'b0001); tick();
    chk("full_after_lsu", 64'(wf_full), 0);
    chk("ovf_sticky1", 64'(overflow_err), 1);
    dec(7, 4'b1000, 0, 0, 0, 10'h220, 0, 4'b0000); tick();
    chk("full_refill", 64'(wf_full), 64'h80);
    alu(7, 10'h210, 4'b0000);
    dec(7, 4'b1000, 0, 0, 0, 10'h230, 0, 4'b0000); tick();
    chk("full_reuse", 64'(wf_full), 64'h80);
    dec(7, 4'b0011, 10'h230, 10'h210, 0, 0, 0, 4'b0001); tick();
    chk("ovf_sticky2", 64'(overflow_err), 1);

    dec(2, 4'b1000, 0, 0, 0, 10'h209, 0, 4'b0000); tick();
    dec(2, 4'b0001, 10'h209, 0, 0, 0, 0, 4'b0001); tick();
    alu(2, 10'h209, 4'b0001);
    dec(2, 4'b0001, 10'h209, 0, 0, 0, 0, 4'b0000); tick();
    alu(2, 10'h209, 4'b0000); tick();
    dec(2, 4'b1000, 0, 0, 0, 10'h209, 0, 4'b0000); tick();
    dec(2, 4'b1000, 0, 0, 0, 10'h209, 0, 4'b1000); tick();
    dec(2, 4'b0001, 10'h209, 0, 0, 0, 0, 4'b0001); tick();

    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk_all_zero("midreset");
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    dec(7, 4'b0011, 10'h230, 10'h213, 0, 0, 0, 4'b0000); tick();
    dec(2, 4'b1001, 10'h209, 0, 0, 10'h209, 0, 4'b0000); tick();
    chk("full_after_reset", 64'(wf_full), 0);
    chk("ovf_after_reset", 64'(overflow_err), 0);

    tick();
    tick();
    chk("dec_drain", 64'(q_dec.size()), 0);
    chk("alu_drain", 64'(q_alu.size()), 0);
    chk("lsu_drain", 64'(q_lsu.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
